// File: rtl/servo_pkg.sv
// Shared types and widths for the servo motion sequencer and its frame timer.
package servo_pkg;

  localparam int DUTY_W   = 10;
  localparam int STEP_W   = 7;
  localparam int DUTY_MAX = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_tick_o marks the last cycle of each frame.
module servo_frame_timer #(
  parameter int INPUT_FREQ = 50_000_000,
  parameter int REFRESH_HZ = 50,
  localparam int PERIOD_COUNT = INPUT_FREQ / REFRESH_HZ,
  localparam int CNT_W = (PERIOD_COUNT > 1) ? $clog2(PERIOD_COUNT) : 1
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Tick is registered from the next count so it lines up with cnt_q == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/servo_motion_ctrl.sv
// Slews the servo duty level toward commanded targets one step per PWM frame,
// then holds for a settle interval before pulsing done.
module servo_motion_ctrl
  import servo_pkg::*;
#(
  parameter int INPUT_FREQ    = 50_000_000,
  parameter int REFRESH_HZ    = 50,
  parameter int HOME_LEVEL    = 500,
  parameter int MAX_LEVEL     = DUTY_MAX,
  parameter int SETTLE_FRAMES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_level,
  output logic              busy,
  output logic              done,
  output logic              frame_tick
);

  localparam int SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_FRAMES - 1);

  function automatic logic [DUTY_W-1:0] clamp_target(input logic [DUTY_W-1:0] t);
    return (t > DUTY_W'(MAX_LEVEL)) ? DUTY_W'(MAX_LEVEL) : t;
  endfunction

  function automatic logic [STEP_W-1:0] norm_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction

  state_e              state_q;
  logic [DUTY_W-1:0]   duty_q, tgt_q;
  logic [STEP_W-1:0]   stp_q;
  logic [SET_W-1:0]    settle_q;
  logic                busy_q, done_q;
  logic                tick;

  logic signed [DUTY_W:0] diff_d, mag_d;
  logic [DUTY_W-1:0]      ramp_d;
  logic                   arrive_d;

  servo_frame_timer #(
    .INPUT_FREQ (INPUT_FREQ),
    .REFRESH_HZ (REFRESH_HZ)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_o (tick)
  );

  // Within one step of target we land exactly on it, so stepping cannot overshoot.
  always_comb begin
    diff_d   = $signed({1'b0, tgt_q}) - $signed({1'b0, duty_q});
    mag_d    = (diff_d < 0) ? -diff_d : diff_d;
    arrive_d = (mag_d <= $signed({{(DUTY_W + 1 - STEP_W){1'b0}}, stp_q}));
    ramp_d   = (diff_d < 0) ? duty_q - DUTY_W'(stp_q) : duty_q + DUTY_W'(stp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= DUTY_W'(HOME_LEVEL);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            tgt_q   <= clamp_target(cmd_target);
            stp_q   <= norm_step(cmd_step);
            state_q <= RAMP;
            busy_q  <= 1'b1;
          end
        end
        RAMP: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (arrive_d) begin
              duty_q   <= tgt_q;
              settle_q <= '0;
              if (SETTLE_FRAMES == 0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= SETTLE;
              end
            end else begin
              duty_q <= ramp_d;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (settle_q == SET_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign duty_level = duty_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_tick = tick;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Scoreboard bench for servo_motion_ctrl with a 20-cycle frame.
module tb_servo_motion_ctrl;
  import servo_pkg::*;

  typedef struct {
    bit is_done;
    int value;
    bit align;
    int ticks;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_target;
  logic [STEP_W-1:0] cmd_step;
  logic              abort;
  logic [DUTY_W-1:0] duty_level;
  logic              busy;
  logic              done;
  logic              frame_tick;

  bit mon_en      = 1'b0;
  bit period_skip = 1'b0;

  servo_motion_ctrl #(
    .INPUT_FREQ (1000),
    .REFRESH_HZ (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .abort      (abort),
    .duty_level (duty_level),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_duty(input int v, input bit align);
    exp_t e;
    e.is_done = 1'b0; e.value = v; e.align = align; e.ticks = -1;
    sbq.push_back(e);
  endtask

  task automatic push_done(input int ticks);
    exp_t e;
    e.is_done = 1'b1; e.value = 0; e.align = 1'b0; e.ticks = ticks;
    sbq.push_back(e);
  endtask

  // Called at a negedge while the DUT is idle.
  task automatic send_cmd(input int t, input int s);
    cmd_valid  = 1'b1;
    cmd_target = DUTY_W'(t);
    cmd_step   = STEP_W'(s);
    @(negedge clk);
    cmd_valid  = 1'b0;
    chk("accept_busy", int'(busy), 1);
  endtask

  task automatic wait_done(output int ticks);
    int n;
    n = 0;
    ticks = 0;
    while (!done && n < 2000) begin
      if (frame_tick) ticks++;
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic wait_duty(input int v);
    int n;
    n = 0;
    while (int'(duty_level) != v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_duty", int'(duty_level), v);
  endtask

  // Monitor: pops expected events whenever duty changes or done pulses.
  logic [DUTY_W-1:0] prev_duty;
  bit                tick_prev = 1'b0;
  bit                have_tick = 1'b0;
  int                gap = 0;
  int                since = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_duty = duty_level;
      end else begin
        gap++;
        if (duty_level != prev_duty) begin
          chk("duty_range", int'(duty_level > DUTY_W'(1000)), 0);
          if (sbq.size() == 0) begin
            chk("unexpected_duty", int'(duty_level), int'(prev_duty));
          end else begin
            e = sbq.pop_front();
            chk("ev_kind_duty", int'(e.is_done), 0);
            chk("duty_value", int'(duty_level), e.value);
            if (e.align) chk("step_after_tick", int'(tick_prev), 1);
          end
          since = 0;
        end
        if (done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
          end else begin
            e = sbq.pop_front();
            chk("ev_kind_done", int'(e.is_done), 1);
            chk("done_busy", int'(busy), 0);
            if (e.ticks >= 0) chk("settle_ticks", since, e.ticks);
          end
        end
        if (frame_tick) begin
          if (have_tick && !period_skip) chk("tick_period", gap, 20);
          period_skip = 1'b0;
          have_tick   = 1'b1;
          gap         = 0;
          since++;
        end
        tick_prev = frame_tick;
        prev_duty = duty_level;
      end
    end
  end

  initial begin
    int tk;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_duty", int'(duty_level), 500);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_count", int'(dut.u_timer.cnt_q), 0);

    // 1: idle
    repeat (100) @(negedge clk);
    chk("idle_duty", int'(duty_level), 500);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // 2: 500 -> 600 step 30
    push_duty(530, 1); push_duty(560, 1); push_duty(590, 1); push_duty(600, 1);
    push_done(10);
    send_cmd(600, 30);
    wait_done(tk);
    chk("done_cycle_ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("post_done_ready", int'(cmd_ready), 1);
    chk("post_done_pulse", int'(done), 0);
    chk("s2_final", int'(duty_level), 600);

    // 3: reach 998, then clamped 1023 with step 0
    push_duty(727, 1); push_duty(854, 1); push_duty(981, 1); push_duty(998, 1);
    push_done(10);
    send_cmd(998, 127);
    wait_done(tk);
    @(negedge clk);
    push_duty(999, 1); push_duty(1000, 1); push_done(10);
    send_cmd(1023, 0);
    wait_done(tk);
    @(negedge clk);
    chk("clamp_final", int'(duty_level), 1000);

    // 4: back to 500, then abort mid-ramp toward 100
    push_duty(873, 1); push_duty(746, 1); push_duty(619, 1); push_duty(500, 1);
    push_done(10);
    send_cmd(500, 127);
    wait_done(tk);
    @(negedge clk);
    push_duty(450, 1); push_duty(400, 1);
    send_cmd(100, 50);
    wait_duty(400);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_duty", int'(duty_level), 400);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    push_done(-1);
    send_cmd(400, 10);
    wait_done(tk);
    chk("abort_new_ticks", tk, 11);
    @(negedge clk);

    // 5: accept on a tick with target equal to current
    push_duty(500, 1); push_done(10);
    send_cmd(500, 100);
    wait_done(tk);
    @(negedge clk);
    n = 0;
    while (!frame_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s5_tick_found", int'(frame_tick), 1);
    push_done(-1);
    send_cmd(500, 5);
    wait_done(tk);
    chk("s5_ticks", tk, 11);
    chk("s5_duty", int'(duty_level), 500);
    @(negedge clk);

    // 6: reset mid-ramp at 700
    push_duty(600, 1); push_duty(700, 1); push_duty(500, 0);
    send_cmd(800, 100);
    wait_duty(700);
    rst = 1'b1;
    period_skip = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_duty", int'(duty_level), 500);
    chk("s6_ready", int'(cmd_ready), 1);
    chk("s6_busy", int'(busy), 0);
    chk("s6_done", int'(done), 0);
    chk("s6_count", int'(dut.u_timer.cnt_q), 0);
    repeat (30) @(negedge clk);
    chk("s6_hold", int'(duty_level), 500);
    chk("queue_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
